// File: rtl/data_cache_if.sv
// Core/memory bus bundle for data_cache.
//   cpu_req_*  : core request (valid/ready handshake, byte address, write data, byte mask)
//   cpu_resp_* : one-cycle response pulse with read data
//   mem_req_*  : line request to main memory (valid/ready, rw, line address, writeback line)
//   mem_resp_* : fill line returned by main memory
// slave  : the cache's view (consumes core requests, issues memory requests)
// master : the environment's view (core plus main memory)
interface data_cache_if;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic [31:0]  cpu_req_addr;
    logic [31:0]  cpu_req_data;
    logic [3:0]   cpu_req_write;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_data;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    modport slave (
        input  cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
    );

    modport master (
        output cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
    );
endinterface

// File: rtl/data_cache.sv
// Blocking, direct-mapped, write-back, write-allocate data cache.
// One word read or byte-masked write accepted per cycle; hit data returned the
// cycle after acceptance. Misses stall the core and move whole 128-bit lines.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset (clears valid/dirty, returns to idle)
//   bus   : data_cache_if.slave, core request/response and memory line port
module data_cache #(
    parameter int unsigned LINES = 64
) (
    input logic         clk,
    input logic         reset,
    data_cache_if.slave bus
);
    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = 28 - IW;

    typedef enum logic [2:0] {StIdle, StCompare, StWbReq, StFillReq, StFillWait} state_t;

    state_t state_q, state_d;

    // Line storage, all in flops.
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [127:0]     data_q [LINES];

    // Latched request.
    logic [31:2] req_addr_q;
    logic [31:0] req_data_q;
    logic [3:0]  req_write_q;

    logic [1:0]    req_word;
    logic [IW-1:0] req_index;
    logic [TW-1:0] req_tag;
    logic [127:0]  line;
    logic [127:0]  merged;
    logic [31:0]   sel_word;
    logic          hit;

    logic         req_ready;
    logic         resp_valid;
    logic [31:0]  resp_data;
    logic         mem_valid;
    logic         mem_rw;
    logic [27:0]  mem_addr;
    logic [127:0] mem_data;
    logic         line_we;
    logic         fill_we;
    logic         accept;

    // Byte-offset bits carry no information for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.cpu_req_addr[1:0];

    assign req_word  = req_addr_q[3:2];
    assign req_index = req_addr_q[IW+3:4];
    assign req_tag   = req_addr_q[31:IW+4];
    assign line      = data_q[req_index];
    assign hit       = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign sel_word  = line[32*req_word +: 32];

    always_comb begin
        merged = line;
        for (int b = 0; b < 4; b++) begin
            if (req_write_q[b]) begin
                merged[32*req_word + 8*b +: 8] = req_data_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        mem_valid  = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        line_we    = 1'b0;
        fill_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (bus.cpu_req_valid) state_d = StCompare;
            end
            StCompare: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    req_ready  = 1'b1;
                    if (|req_write_q) line_we   = 1'b1;
                    else              resp_data = sel_word;
                    state_d = bus.cpu_req_valid ? StCompare : StIdle;
                end else if (valid_q[req_index] && dirty_q[req_index]) begin
                    state_d = StWbReq;
                end else begin
                    state_d = StFillReq;
                end
            end
            StWbReq: begin
                // Victim tag/data are indexed by the held request, so they stay stable.
                mem_valid = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = {tag_q[req_index], req_index};
                mem_data  = line;
                if (bus.mem_req_ready) state_d = StFillReq;
            end
            StFillReq: begin
                mem_valid = 1'b1;
                mem_addr  = req_addr_q[31:4];
                if (bus.mem_req_ready) state_d = StFillWait;
            end
            StFillWait: begin
                if (bus.mem_resp_valid) begin
                    fill_we = 1'b1;
                    state_d = StCompare;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs read as idle/zero for as long as reset is held.
        if (reset) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_data  = '0;
            mem_valid  = 1'b0;
            mem_rw     = 1'b0;
            mem_addr   = '0;
            mem_data   = '0;
            line_we    = 1'b0;
            fill_we    = 1'b0;
        end
    end

    assign accept = bus.cpu_req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (line_we) begin
                data_q[req_index]  <= merged;
                dirty_q[req_index] <= 1'b1;
            end
            if (fill_we) begin
                data_q[req_index]  <= bus.mem_resp_data;
                tag_q[req_index]   <= req_tag;
                valid_q[req_index] <= 1'b1;
                dirty_q[req_index] <= 1'b0;
            end
        end
    end

    // Request register; only meaningful after an accept, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr_q  <= bus.cpu_req_addr[31:2];
            req_data_q  <= bus.cpu_req_data;
            req_write_q <= bus.cpu_req_write;
        end
    end

    assign bus.cpu_req_ready  = req_ready;
    assign bus.cpu_resp_valid = resp_valid;
    assign bus.cpu_resp_data  = resp_data;
    assign bus.mem_req_valid  = mem_valid;
    assign bus.mem_req_rw     = mem_rw;
    assign bus.mem_req_addr   = mem_addr;
    assign bus.mem_req_data   = mem_data;
endmodule
